instr_fetch: RTL and testbench

Instruction fetch stage of the RV64 CPU, directly upstream of the main control decoder. Holds the PC and runs a req/ack handshake with instruction memory of variable latency. Presents one 32-bit instruction, its 7-bit opcode field and its PC to the decode stage. Holds the instruction under downstream stall, and redirects on taken branches, dropping any in-flight fetch.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/instr_fetch_if.sv | 39 +++
 rtl/sat_counter.sv | 29 ++
 rtl/instr_fetch.sv | 131 +++++++++++++
 tb/tb_instr_fetch.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg                                                              |
// | Opcode constants, fetch FSM encoding and default reset PC.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cpu_pkg;

    localparam logic [6:0]  OP_RTYPE = 7'b0110011;
    localparam logic [6:0]  OP_LD    = 7'b0000011;
    localparam logic [6:0]  OP_SD    = 7'b0100011;
    localparam logic [6:0]  OP_BEQ   = 7'b1100011;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_DROP  = 2'd1,
        S_VALID = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_if                                                       |
// | Instruction-memory handshake plus decode-side signals of fetch.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface instr_fetch_if #(
    parameter int XLEN = 64
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    logic            stall;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;

    logic            instr_valid;
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [XLEN-1:0] pc_out;
    logic            misalign_err;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  stall, branch_taken, branch_target,
        output instr_valid, instr, opcode, pc_out, misalign_err
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output stall, branch_taken, branch_target,
        input  instr_valid, instr, opcode, pc_out, misalign_err
    );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter                                                          |
// | Width-parameterised up-counter that sticks at all-ones.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (en_i && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch                                                          |
// | RV64 fetch stage: PC, imem req/ack, stall hold and branch redirect.  |
// | Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_wait.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC[XLEN-1:0]
) (
    input  wire          clk,
    input  wire          rst,
    instr_fetch_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_wait
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] drop_addr_q, drop_addr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic [31:0]     instr_q, instr_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] w_target;

    // Redirects always land word-aligned; a bad target only raises the flag.
    assign w_target = {bus.branch_target[XLEN-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            drop_addr_q <= '0;
            pc_out_q    <= '0;
            instr_q     <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            pc_out_q    <= pc_out_d;
            instr_q     <= instr_d;
            misalign_q  <= misalign_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        pc_out_d    = pc_out_q;
        instr_d     = instr_q;
        misalign_d  = misalign_q | (bus.branch_taken & (bus.branch_target[1:0] != 2'b00));

        case (state_q)
            S_REQ: begin
                if (bus.branch_taken) begin
                    pc_d = w_target;
                    // Without an ack the old request must be seen through to completion.
                    if (!bus.imem_ack) begin
                        drop_addr_d = pc_q;
                        state_d     = S_DROP;
                    end
                end else if (bus.imem_ack) begin
                    instr_d  = bus.imem_rdata;
                    pc_out_d = pc_q;
                    state_d  = S_VALID;
                end
            end
            S_DROP: begin
                if (bus.branch_taken) begin
                    pc_d = w_target;
                end
                if (bus.imem_ack) begin
                    state_d = S_REQ;
                end
            end
            S_VALID: begin
                if (bus.branch_taken) begin
                    pc_d    = w_target;
                    state_d = S_REQ;
                end else if (!bus.stall) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    assign bus.imem_req     = !rst && ((state_q == S_REQ) || (state_q == S_DROP));
    assign bus.imem_addr    = (state_q == S_DROP) ? drop_addr_q : pc_q;
    assign bus.instr_valid  = (state_q == S_VALID);
    assign bus.instr        = instr_q;
    assign bus.opcode       = instr_q[6:0];
    assign bus.pc_out       = pc_out_q;
    assign bus.misalign_err = misalign_q;

`ifdef FETCH_PERF_CNT_EN
    logic w_consumed;
    logic w_waiting;

    assign w_consumed = (state_q == S_VALID) && !bus.stall && !bus.branch_taken;
    assign w_waiting  = bus.imem_req && !bus.imem_ack;

    sat_counter #(.WIDTH(32)) u_perf_fetched (
        .clk     (clk),
        .rst     (rst),
        .en_i    (w_consumed),
        .count_o (perf_fetched)
    );

    sat_counter #(.WIDTH(32)) u_perf_wait (
        .clk     (clk),
        .rst     (rst),
        .en_i    (w_waiting),
        .count_o (perf_wait)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_fetch                                                       |
// | Random stimulus, behavioural PC-stream model and scoreboard.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam int              XLEN     = 64;
    localparam logic [XLEN-1:0] RESET_PC = 64'h0;
    localparam int              N_CYCLES = 4000;
    localparam int              IDLE_MAX = 100;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests = 0;
    int fails = 0;

    exp_t        exp_q[$];
    logic        model_misalign = 1'b0;
    logic [63:0] model_next_pc  = 64'h0;
    int unsigned model_consumed = 0;
    int unsigned model_wait     = 0;
    bit          zero_wait      = 1'b1;

    instr_fetch_if #(.XLEN(XLEN)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_wait;
`endif

    instr_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_wait    (perf_wait)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int detail);
        tests++;
        fails++;
        $display("FAIL %s: got %0d, required an instruction delivery", name, detail);
    endtask

    // Memory image: every word is address-dependent, opcode cycles over the four classes.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] w;
        w = a[31:0] ^ a[63:32] ^ 32'h5EED_1234;
        case (a[3:2])
            2'd0:    w[6:0] = OP_RTYPE;
            2'd1:    w[6:0] = OP_LD;
            2'd2:    w[6:0] = OP_SD;
            default: w[6:0] = OP_BEQ;
        endcase
        return w;
    endfunction

    function automatic exp_t mk(input logic [63:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        return e;
    endfunction

    // Driver: applies last cycle's decode-side events to the model, then drives new ones.
    initial begin : driver
        logic        prev_rst, prev_valid, prev_stall, prev_br;
        logic [63:0] prev_tgt, tgt;
        int unsigned r;
        prev_rst = 1'b1; prev_valid = 1'b0; prev_stall = 1'b0; prev_br = 1'b0; prev_tgt = '0;
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            if (prev_rst) begin
                model_next_pc  = RESET_PC;
                model_misalign = 1'b0;
                model_consumed = 0;
                model_wait     = 0;
                exp_q.delete();
                exp_q.push_back(mk(model_next_pc));
            end else if (prev_br) begin
                if (prev_tgt[1:0] != 2'b00) model_misalign = 1'b1;
                model_next_pc = {prev_tgt[63:2], 2'b00};
                exp_q.delete();
                exp_q.push_back(mk(model_next_pc));
            end else if (prev_valid && !prev_stall) begin
                model_next_pc  = model_next_pc + 64'd4;
                model_consumed = model_consumed + 1;
                exp_q.push_back(mk(model_next_pc));
            end
            #1;
            zero_wait = (cyc < 60);
            rst       = (cyc < 3) || ((cyc >= 60) && ($urandom_range(0, 199) == 0));
            bus.stall = (cyc >= 60) && ($urandom_range(0, 9) < 3);
            bus.branch_taken = (cyc >= 60) && ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 19);
            if (r < 10)      tgt = 64'($urandom_range(0, 4095)) & ~64'h3;
            else if (r < 18) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'({$urandom_range(0, 3), 2'b00});
            else             tgt = {$urandom, $urandom};
            bus.branch_target = tgt;
            prev_rst   = rst;
            prev_valid = bus.instr_valid;
            prev_stall = bus.stall;
            prev_br    = bus.branch_taken;
            prev_tgt   = tgt;
        end
        @(posedge clk);
        if (!prev_rst && !prev_br && prev_valid && !prev_stall) model_consumed = model_consumed + 1;
        @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
        if (!prev_rst) begin
            check("perf_fetched", 64'(perf_fetched), 64'(model_consumed));
            check("perf_wait", 64'(perf_wait), 64'(model_wait));
        end
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Instruction memory: random latency 0..3, address must stay put until ack.
    initial begin : memory
        bit          busy;
        bit          pend_wait;
        int          cnt;
        logic [63:0] a0;
        busy = 1'b0; pend_wait = 1'b0; cnt = 0; a0 = '0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        forever begin
            @(posedge clk);
            if (pend_wait) model_wait = model_wait + 1;
            pend_wait = 1'b0;
            #2;
            if (!bus.imem_req) begin
                busy = 1'b0;
                bus.imem_ack = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    a0   = bus.imem_addr;
                    cnt  = zero_wait ? 0 : int'($urandom_range(0, 3));
                end else begin
                    check("imem_addr_stable", bus.imem_addr, a0);
                end
                if (cnt == 0) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = mem_word(a0);
                    busy           = 1'b0;
                end else begin
                    bus.imem_ack   = 1'b0;
                    bus.imem_rdata = $urandom;
                    cnt            = cnt - 1;
                    pend_wait      = 1'b1;
                end
            end
        end
    end

    // Monitor: pops an expectation on each new instruction presented to decode.
    initial begin : monitor
        logic prev_v, prev_r;
        exp_t cur;
        int   idle;
        prev_v = 1'b0; prev_r = 1'b1; idle = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("imem_req_in_rst", 64'(bus.imem_req), 64'd0);
                prev_v = 1'b0; prev_r = 1'b1; idle = 0;
                continue;
            end
            if (prev_r) begin
                check("req_after_rst", 64'(bus.imem_req), 64'd1);
                check("addr_after_rst", bus.imem_addr, RESET_PC);
                check("valid_after_rst", 64'(bus.instr_valid), 64'd0);
            end
            prev_r = 1'b0;
            check("misalign_err", 64'(bus.misalign_err), 64'(model_misalign));
            if (bus.instr_valid && !prev_v) begin
                idle = 0;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_delivery", 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("pc_out", bus.pc_out, cur.pc);
                    check("instr", 64'(bus.instr), 64'(cur.instr));
                    check("opcode", 64'(bus.opcode), 64'(cur.instr[6:0]));
                end
            end else if (bus.instr_valid) begin
                check("hold_pc_out", bus.pc_out, cur.pc);
                check("hold_instr", 64'(bus.instr), 64'(cur.instr));
            end else begin
                idle++;
                if (idle > IDLE_MAX) begin
                    fail_now("delivery_timeout", idle);
                    idle = 0;
                end
            end
            prev_v = bus.instr_valid;
        end
    end

endmodule
`default_nettype wire
